fantasticfft_fft8_framer: RTL and testbench
===========================================

# fantasticfft_fft8_framer

Upstream feeder for the FFT8 core. Accepts a stream of signed integer samples over a valid/ready handshake, converts each to Q8.8 with saturation, and collects them into 8-sample frames. Each complete frame is presented in parallel on `x[0:7]` with `out_valid`, which drives the FFT8 interface's `x[]` and `isValid` directly. One capture buffer plus one output register form a two-deep frame pipeline, so streaming runs without bubbles when downstream is always ready.

## Interface
- `IN_W`, 12: input sample width, signed two's complement integer.
- `SHIFT`, 0: Q8.8 value equals `in_data / 2^SHIFT`; legal range 0..8.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_data` in IN_W: signed input sample.
- `in_valid` in 1: `in_data` and `in_last` are valid.
- `in_ready` out 1: framer accepts the sample this cycle.
- `in_last` in 1: final sample of a short frame; remaining slots are zero-padded.
- `x[0:7]` out 8×16: Q8.8 frame, bits [7:-8]; `x[0]` is the first sample accepted.
- `out_valid` out 1: frame on `x` is valid; maps to FFT8 `isValid`.
- `out_ready` in 1: downstream takes the frame; tied 1 when driving FFT8.
- `out_padded` out 1: current frame was closed early by `in_last`.
- `sat_flag` out 1: sticky; set when any sample saturated; cleared only by reset.

## Operation
- Handshake: a sample is accepted on a rising edge where `in_valid && in_ready`. Output transfer occurs on an edge where `out_valid && out_ready`.
- Conversion:
  - Sign-extend, then shift left arithmetically by `8-SHIFT`.
  - If the result is outside the 16-bit signed range, clamp to 0x7FFF or 0x8000 and set `sat_flag`.
- Capture state machine, two states:
  - FILL, with write index `idx` 0..7:
    - `in_ready`=1.
    - Each accept writes slot `idx`.
    - If `idx`==7 or `in_last`, the frame closes. Slots above `idx` are forced to 0, `idx` returns to 0, and the padded flag is captured.
  - Frame close when the output register is free (`!out_valid || out_ready` that cycle): the frame loads into `x` and `out_valid` is set. State stays FILL.
  - Frame close when the output register is busy: go to WAIT.
  - WAIT: `in_ready`=0. On an edge with `out_ready`=1, load the capture buffer into `x`, hold `out_valid`=1, and return to FILL with `idx`=0.
- `out_valid` clears on a transfer edge when no new frame loads on that edge.
- `x` and `out_padded` hold stable while `out_valid`=1 and `out_ready`=0.
- `in_last` with `idx`==7 is a normal full frame; `out_padded`=0.
- `in_last` is ignored unless `in_valid && in_ready`.

## Timing
- Reset values, asynchronous, while `rst_n`=0:
  - `out_valid`=0, `x[*]`=0, `out_padded`=0, `sat_flag`=0.
  - State FILL, `idx`=0.
  - `in_ready`=0 while `rst_n`=0, and 1 from the first cycle after release.
- Latency: `out_valid` is high in the cycle immediately after the cycle holding the closing handshake. There is no combinational path from `in_*` to `x` or `out_valid`.
- `in_ready` is a function of registered state only. It does not depend on `out_ready` combinationally.
- Throughput: with `out_ready`=1, there is one frame per 8 accepted samples and `in_ready` never drops. `out_valid` is a one-cycle pulse per frame, which FFT8 requires.
- With `out_ready` held 0: the framer accepts one full frame into `x` and a second into the capture buffer, then goes to WAIT and stalls input.
- Reset asserted mid-frame discards any partial frame and any pending frame.

## Structure
- Shared package `fantasticfft_pkg`:
  - `typedef logic [7:-8] fixed_q88_t`
  - `localparam FFT8_N = 8`
  - `localparam Q88_MAX = 16'h7FFF`, `Q88_MIN = 16'h8000`
  - Framer state enum `{FILL, WAIT}`
- Sub-module `fantasticfft_sat_q88`: combinational integer-to-Q8.8 shift-and-saturate. Parameters `IN_W` and `SHIFT`; output `q`, output `sat`.

## Test plan
- `IN_W`=12, `SHIFT`=0, `out_ready`=1, samples 1..8 back-to-back -> one `out_valid` pulse the cycle after the 8th accept; `x`=0x0100,0x0200,…,0x0800; `in_ready` constantly 1.
- `out_ready`=1, continuous stream of 24 samples -> exactly 3 single-cycle pulses spaced 8 cycles apart; no `in_ready` deassertion.
- Samples 5,6,7 with `in_last` on 7 -> `x`=0x0500,0x0600,0x0700,0,0,0,0,0; `out_padded`=1; next frame starts at `x[0]`.
- `SHIFT`=0, input 2047 and -2048 -> 0x7FFF and 0x8000, `sat_flag`=1 and sticky. `SHIFT`=4, input 2047 -> 0x7FF0 with no saturation.
- `out_ready`=0, 17 samples offered -> the first frame is held on `x`, the second is captured, `in_ready`=0 after the 16th accept. Raising `out_ready` -> the second frame appears the next cycle, then the 17th sample is accepted.
- Assert `rst_n`=0 after 5 samples -> all outputs reset immediately. After release, samples 1..8 produce a clean frame with no stale data.

Source files
------------

// File: rtl/fantasticfft_pkg.sv
// Shared types and constants for the FFT8 front end.
package fantasticfft_pkg;

    // Q8.8 fixed point: bits [7:0] integer, bits [-1:-8] fraction.
    typedef logic [7:-8] fixed_q88_t;

    localparam int FFT8_N = 8;

    localparam logic [15:0] Q88_MAX = 16'h7FFF;
    localparam logic [15:0] Q88_MIN = 16'h8000;

    // Framer capture state.
    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } framer_state_t;

    // A frame closes on the eighth slot or on an early in_last.
    function automatic logic frame_closes(input logic [2:0] idx, input logic last);
        return (idx == 3'd7) || last;
    endfunction

endpackage

// File: rtl/fantasticfft_sat_q88.sv
// Combinational signed-integer to Q8.8 conversion with saturation.
// The sample is sign-extended into a word wide enough to hold the full
// shifted value, then range-checked against the 16-bit signed limits.
module fantasticfft_sat_q88
    import fantasticfft_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int SHIFT = 0
) (
    input  logic [IN_W-1:0] in_data,
    output fixed_q88_t      q,
    output logic            sat
);

    // Working width: at least 17 bits so bit 15 and everything above it exist.
    localparam int WIDE = (IN_W + 9 > 17) ? IN_W + 9 : 17;

    logic [WIDE-1:0]  ext_s;
    logic [WIDE-1:0]  shifted_s;
    logic [WIDE-16:0] top_s;

    // Sign-extend, scale by 2^(8-SHIFT), and clamp when the upper bits disagree with the sign.
    always_comb begin
        ext_s     = {{(WIDE - IN_W){in_data[IN_W-1]}}, in_data};
        shifted_s = ext_s << (8 - SHIFT);
        top_s     = shifted_s[WIDE-1:15];
        if ((top_s == '0) || (top_s == '1)) begin
            q   = shifted_s[15:0];
            sat = 1'b0;
        end else if (shifted_s[WIDE-1]) begin
            q   = Q88_MIN;
            sat = 1'b1;
        end else begin
            q   = Q88_MAX;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/fantasticfft_fft8_framer.sv
// Collects a valid/ready sample stream into 8-sample Q8.8 frames for FFT8.
// A capture buffer plus the output register form a two-deep frame pipeline;
// in_ready comes from a register so there is no path from out_ready to in_ready.
module fantasticfft_fft8_framer
    import fantasticfft_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    output fixed_q88_t      x [0:FFT8_N-1],
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_padded,
    output logic            sat_flag
);

    framer_state_t state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    fixed_q88_t    buf_q [0:FFT8_N-1];
    fixed_q88_t    buf_d [0:FFT8_N-1];
    logic          buf_pad_q, buf_pad_d;
    fixed_q88_t    x_q [0:FFT8_N-1];
    fixed_q88_t    x_d [0:FFT8_N-1];
    logic          out_valid_q, out_valid_d;
    logic          out_padded_q, out_padded_d;
    logic          sat_q, sat_d;
    logic          in_ready_q, in_ready_d;

    fixed_q88_t    conv_q_s;
    logic          conv_sat_s;
    fixed_q88_t    frame_s [0:FFT8_N-1];
    logic          accept_s;
    logic          close_s;
    logic          out_free_s;
    logic          pad_s;

    fantasticfft_sat_q88 #(
        .IN_W  (IN_W),
        .SHIFT (SHIFT)
    ) u_sat (
        .in_data (in_data),
        .q       (conv_q_s),
        .sat     (conv_sat_s)
    );

    // Capture buffer as it would look with the current sample in slot idx and zeros above it.
    always_comb begin
        for (int i = 0; i < FFT8_N; i++) begin
            if (i < int'(idx_q)) begin
                frame_s[i] = buf_q[i];
            end else if (i == int'(idx_q)) begin
                frame_s[i] = conv_q_s;
            end else begin
                frame_s[i] = '0;
            end
        end
    end

    // Next-state logic for capture FSM, output register and sticky saturation flag.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        buf_d        = buf_q;
        buf_pad_d    = buf_pad_q;
        x_d          = x_q;
        out_padded_d = out_padded_q;
        sat_d        = sat_q;

        accept_s   = in_valid && in_ready_q && (state_q == FILL);
        close_s    = accept_s && frame_closes(idx_q, in_last);
        out_free_s = !out_valid_q || out_ready;
        pad_s      = in_last && (idx_q != 3'd7);

        // A transfer drops out_valid unless a new frame loads on the same edge.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            FILL: begin
                if (accept_s) begin
                    buf_d = frame_s;
                    sat_d = sat_q | conv_sat_s;
                    if (close_s) begin
                        idx_d = 3'd0;
                        if (out_free_s) begin
                            x_d          = frame_s;
                            out_padded_d = pad_s;
                            out_valid_d  = 1'b1;
                        end else begin
                            buf_pad_d = pad_s;
                            state_d   = WAIT;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            WAIT: begin
                if (out_ready) begin
                    x_d          = buf_q;
                    out_padded_d = buf_pad_q;
                    out_valid_d  = 1'b1;
                    idx_d        = 3'd0;
                    state_d      = FILL;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = 3'd0;
            end
        endcase

        in_ready_d = (state_d == FILL);
    end

    // State and datapath registers; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            idx_q        <= 3'd0;
            buf_pad_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_padded_q <= 1'b0;
            sat_q        <= 1'b0;
            in_ready_q   <= 1'b0;
            for (int i = 0; i < FFT8_N; i++) begin
                buf_q[i] <= '0;
                x_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            buf_pad_q    <= buf_pad_d;
            out_valid_q  <= out_valid_d;
            out_padded_q <= out_padded_d;
            sat_q        <= sat_d;
            in_ready_q   <= in_ready_d;
            for (int i = 0; i < FFT8_N; i++) begin
                buf_q[i] <= buf_d[i];
                x_q[i]   <= x_d[i];
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign x          = x_q;
    assign out_valid  = out_valid_q;
    assign out_padded = out_padded_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_fantasticfft_fft8_framer.sv
// Self-checking bench for the FFT8 framer. Two instances (SHIFT=0 and SHIFT=4)
// see the same stream; expected frames are queued as samples are accepted and
// compared when the framer hands a frame downstream.
module tb_fantasticfft_fft8_framer;
    import fantasticfft_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] in_data = 12'd0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready0, in_ready4, out_valid0, out_valid4;
    logic        out_padded0, out_padded4, sat0, sat4;
    fixed_q88_t  x0 [0:7];
    fixed_q88_t  x4 [0:7];

    always #5 clk = ~clk;

    fantasticfft_fft8_framer #(.IN_W(12), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .in_last(in_last), .x(x0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_padded(out_padded0), .sat_flag(sat0));

    fantasticfft_fft8_framer #(.IN_W(12), .SHIFT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready4), .in_last(in_last), .x(x4), .out_valid(out_valid4),
        .out_ready(out_ready), .out_padded(out_padded4), .sat_flag(sat4));

    typedef struct packed {
        logic [7:0][15:0] f0;
        logic [7:0][15:0] f4;
        logic             padded;
    } frame_t;

    typedef struct packed {
        logic [11:0] din;
        logic [15:0] e0;
        logic [15:0] e4;
        logic        s0;
    } vec_t;

    int               n_checks = 0;
    int               n_fail = 0;
    int               cyc = 0;
    frame_t           sb [$];
    int               pulse_cyc [$];
    logic [7:0][15:0] m0, m4;
    int               m_idx = 0;
    logic             ready_watch = 1'b0;
    frame_t           mf;
    vec_t             vecs [0:7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] conv(input int d, input int sh);
        int v;
        v = d * (1 << (8 - sh));
        if (v > 32767) return 16'h7FFF;
        else if (v < -32768) return 16'h8000;
        else return v[15:0];
    endfunction

    function automatic logic conv_sat(input int d, input int sh);
        int v;
        v = d * (1 << (8 - sh));
        return (v > 32767) || (v < -32768);
    endfunction

    task automatic model_accept(input logic last, input logic [15:0] e0, input logic [15:0] e4);
        frame_t f;
        m0[m_idx] = e0;
        m4[m_idx] = e4;
        if (m_idx == 7 || last) begin
            f.f0     = m0;
            f.f4     = m4;
            f.padded = last && (m_idx != 7);
            sb.push_back(f);
            m0    = '0;
            m4    = '0;
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    // Offer one sample (called at posedge+2); returns at posedge+2 after the accepting edge.
    task automatic send_exp(input logic [11:0] d, input logic last,
                            input logic [15:0] e0, input logic [15:0] e4);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        n = 0;
        while (in_ready0 !== 1'b1 && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed %0b for %0d cycles, required 1", in_ready0, n);
        end else begin
            model_accept(last, e0, e4);
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input int d, input logic last);
        logic [31:0] dv;
        dv = d;
        send_exp(dv[11:0], last, conv(d, 0), conv(d, 4));
    endtask

    task automatic model_flush();
        sb.delete();
        m0    = '0;
        m4    = '0;
        m_idx = 0;
    endtask

    // Cycle counter used to measure output pulse spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: on every transfer cycle compare both framers against the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ready_watch) check("in_ready_high", {31'd0, in_ready0}, 32'd1);
            if (out_valid0 && out_ready) begin
                pulse_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: out_valid=1 with no frame expected");
                end else begin
                    mf = sb.pop_front();
                    for (int i = 0; i < 8; i++) begin
                        check($sformatf("x_shift0[%0d]", i), {16'd0, x0[i]}, {16'd0, mf.f0[i]});
                        check($sformatf("x_shift4[%0d]", i), {16'd0, x4[i]}, {16'd0, mf.f4[i]});
                    end
                    check("out_padded0", {31'd0, out_padded0}, {31'd0, mf.padded});
                    check("out_padded4", {31'd0, out_padded4}, {31'd0, mf.padded});
                    check("out_valid4", {31'd0, out_valid4}, 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{12'h7FF, 16'h7FFF, 16'h7FF0, 1'b1};
        vecs[1] = '{12'h800, 16'h8000, 16'h8000, 1'b1};
        vecs[2] = '{12'h001, 16'h0100, 16'h0010, 1'b0};
        vecs[3] = '{12'hFFF, 16'hFF00, 16'hFFF0, 1'b0};
        vecs[4] = '{12'h07F, 16'h7F00, 16'h07F0, 1'b0};
        vecs[5] = '{12'h080, 16'h7FFF, 16'h0800, 1'b1};
        vecs[6] = '{12'hF80, 16'h8000, 16'hF800, 1'b0};
        vecs[7] = '{12'hF7F, 16'h8000, 16'hF7F0, 1'b1};
        m0 = '0;
        m4 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready0}, 32'd0);
        check("rst_out_padded", {31'd0, out_padded0}, 32'd0);
        check("rst_sat_flag", {31'd0, sat0}, 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_x[%0d]", i), {16'd0, x0[i]}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("in_ready_after_release", {31'd0, in_ready0}, 32'd1);

        // Samples 1..8 back-to-back: one pulse the cycle after the 8th accept
        ready_watch = 1'b1;
        pulse_cyc.delete();
        for (int i = 1; i <= 8; i++) send(i, 1'b0);
        check("latency_out_valid", {31'd0, out_valid0}, 32'd1);
        @(posedge clk); #2;
        check("pulse_one_cycle", {31'd0, out_valid0}, 32'd0);
        check("pulse_count_1", pulse_cyc.size(), 32'd1);

        // Short frame closed by in_last, then a full frame starting at slot 0
        send(5, 1'b0);
        send(6, 1'b0);
        send(7, 1'b1);
        check("padded_flag", {31'd0, out_padded0}, 32'd1);
        for (int i = 1; i <= 8; i++) send(i, 1'b0);
        check("no_sat_yet0", {31'd0, sat0}, 32'd0);

        // Conversion table: saturation boundaries at both shifts
        for (int k = 0; k < 8; k++) send_exp(vecs[k].din, 1'b0, vecs[k].e0, vecs[k].e4);
        @(posedge clk); #2;
        check("sat_flag_set", {31'd0, sat0}, 32'd1);
        check("sat_flag_shift4", {31'd0, sat4}, 32'd0);

        // Continuous 24-sample stream: three pulses spaced 8 cycles
        pulse_cyc.delete();
        for (int i = 0; i < 24; i++) send(i * 97 - 1000, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        check("pulse_count_3", pulse_cyc.size(), 32'd3);
        if (pulse_cyc.size() == 3) begin
            check("pulse_spacing_a", pulse_cyc[1] - pulse_cyc[0], 32'd8);
            check("pulse_spacing_b", pulse_cyc[2] - pulse_cyc[1], 32'd8);
        end
        check("sat_sticky", {31'd0, sat0}, 32'd1);
        ready_watch = 1'b0;

        // Backpressure: frame 1 held on x, frame 2 captured, input stalls
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) send(i, 1'b0);
        check("bp_in_ready_low", {31'd0, in_ready0}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_valid", {31'd0, out_valid0}, 32'd1);
            check("bp_hold_x0", {16'd0, x0[0]}, 32'h0100);
            check("bp_hold_x7", {16'd0, x0[7]}, 32'h0800);
            check("bp_stall", {31'd0, in_ready0}, 32'd0);
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        check("bp_frame2_valid", {31'd0, out_valid0}, 32'd1);
        check("bp_frame2_x0", {16'd0, x0[0]}, 32'h0900);
        check("bp_ready_back", {31'd0, in_ready0}, 32'd1);
        send(17, 1'b1);
        repeat (2) @(posedge clk);
        #2;

        // Reset mid-frame with a frame held on x and a partial frame in capture
        out_ready = 1'b0;
        for (int i = 1; i <= 13; i++) send(i + 20, 1'b0);
        rst_n = 1'b0;
        model_flush();
        #1;
        check("midrst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready0}, 32'd0);
        check("midrst_x0", {16'd0, x0[0]}, 32'd0);
        check("midrst_sat", {31'd0, sat0}, 32'd0);
        check("midrst_padded", {31'd0, out_padded0}, 32'd0);
        @(posedge clk); #2;
        out_ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #2;
        for (int i = 1; i <= 8; i++) send(i, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
